// File: rtl/game_round_ctrl_pkg.sv
// Shared types and helpers for the symbol-counting game round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    ANSWER,
    JUDGE,
    SHOW,
    DONE
  } gameState_t;

  localparam int SYM_W   = 32;
  localparam int SCORE_W = 16;
  localparam int LEVEL_W = 4;
  localparam int MISS_W  = 2;
  localparam int DATA_W  = 8;
  localparam int SEC_W   = 5;

  // Symbol interval for a level: shrinks by one step per level and never
  // drops below the floor. The product is kept at 36 bits so it cannot wrap.
  function automatic logic [SYM_W-1:0] calcPeriod(
    input logic [LEVEL_W-1:0] lvl,
    input logic [SYM_W-1:0]   basePeriod,
    input logic [SYM_W-1:0]   periodStep,
    input logic [SYM_W-1:0]   minPeriod
  );
    logic [35:0] prod;
    prod = 36'(lvl) * 36'(periodStep);
    if (prod > 36'(basePeriod - minPeriod)) begin
      return minPeriod;
    end
    return 32'(36'(basePeriod) - prod);
  endfunction

endpackage

// File: rtl/game_round_ctrl_sec_counter.sv
// Seconds counter shared by every timed state of the round sequencer.
// termTick_o flags the tick that brings the count up to limit_i, so the
// owner can leave the state in that same cycle.
module sec_counter
  import game_pkg::*;
#(
  parameter int W = SEC_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         tick_i,
  input  logic [W-1:0] limit_i,
  output logic         termTick_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clearing takes priority; otherwise advance once per tick.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign termTick_o = tick_i && (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the symbol-counting game: launches each game period,
// collects and judges the player's answer, keeps score/level/misses and
// chains rounds until the miss budget runs out. All outputs are registered.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter logic [31:0] BASE_PERIOD = 32'd100_000_000,
  parameter logic [31:0] PERIOD_STEP = 32'd10_000_000,
  parameter logic [31:0] MIN_PERIOD  = 32'd20_000_000,
  parameter logic [3:0]  MAX_LEVEL   = 4'd7,
  parameter int          ANS_TIMEOUT = 10,
  parameter int          SHOW_SECS   = 3,
  parameter int          RUN_TIMEOUT = 20,
  parameter int          MAX_MISSES  = 3
) (
  input  logic               Clk100M,
  input  logic               Rst_n,
  input  logic               tick1Hz,
  input  logic               startBtn,
  input  logic               submitBtn,
  input  logic [DATA_W-1:0]  playerAnswer,
  input  logic               answerSig,
  input  logic [DATA_W-1:0]  numSpecial,
  output logic               gameSig,
  output logic [SYM_W-1:0]   symGenMax,
  output logic               answerPrompt,
  output logic               resultValid,
  output logic               resultCorrect,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic [MISS_W-1:0]  misses,
  output logic               gameOver,
  output logic               busy
);

  gameState_t         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic [SYM_W-1:0]   symGenMax_q, symGenMax_d;
  logic [DATA_W-1:0]  expected_q, expected_d;
  logic [DATA_W-1:0]  answer_q, answer_d;
  logic               timedOut_q, timedOut_d;
  logic               resultCorrect_q, resultCorrect_d;
  logic               gameSig_q, answerPrompt_q, resultValid_q, gameOver_q, busy_q;

  logic [SEC_W-1:0]   secLimit;
  logic               secClear;
  logic               secTerm;
  logic               judgeCorrect;
  logic [SCORE_W:0]   scoreSum;

  assign secClear = (state_d != state_q);

  sec_counter #(.W(SEC_W)) u_secCounter (
    .clk_i      (Clk100M),
    .rst_ni     (Rst_n),
    .clear_i    (secClear),
    .tick_i     (tick1Hz),
    .limit_i    (secLimit),
    .termTick_o (secTerm)
  );

  // Next-state, seconds limit and datapath updates for the round sequence.
  always_comb begin
    state_d         = state_q;
    score_d         = score_q;
    level_d         = level_q;
    misses_d        = misses_q;
    symGenMax_d     = symGenMax_q;
    expected_d      = expected_q;
    answer_d        = answer_q;
    timedOut_d      = timedOut_q;
    resultCorrect_d = resultCorrect_q;
    secLimit        = '0;
    judgeCorrect    = (answer_q == expected_q) && !timedOut_q;
    scoreSum        = {1'b0, score_q} + (SCORE_W+1)'(level_q) + (SCORE_W+1)'(1);

    case (state_q)
      IDLE, DONE: begin
        if (startBtn) begin
          score_d     = '0;
          level_d     = '0;
          misses_d    = '0;
          symGenMax_d = BASE_PERIOD;
          state_d     = START;
        end
      end
      START: begin
        state_d = RUN;
      end
      RUN: begin
        secLimit = SEC_W'(RUN_TIMEOUT);
        if (answerSig) begin
          expected_d = numSpecial;
          state_d    = ANSWER;
        end else if (secTerm) begin
          state_d = DONE;
        end
      end
      ANSWER: begin
        secLimit = SEC_W'(ANS_TIMEOUT);
        if (submitBtn) begin
          answer_d   = playerAnswer;
          timedOut_d = 1'b0;
          state_d    = JUDGE;
        end else if (secTerm) begin
          timedOut_d = 1'b1;
          state_d    = JUDGE;
        end
      end
      JUDGE: begin
        resultCorrect_d = judgeCorrect;
        if (judgeCorrect) begin
          score_d = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
          level_d = (level_q >= MAX_LEVEL) ? MAX_LEVEL : level_q + LEVEL_W'(1);
        end else if (misses_q != '1) begin
          misses_d = misses_q + MISS_W'(1);
        end
        symGenMax_d = calcPeriod(level_d, BASE_PERIOD, PERIOD_STEP, MIN_PERIOD);
        state_d     = SHOW;
      end
      SHOW: begin
        secLimit = SEC_W'(SHOW_SECS);
        if (secTerm) begin
          state_d = (misses_q == MISS_W'(MAX_MISSES)) ? DONE : START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs follow the state being entered.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q         <= IDLE;
      score_q         <= '0;
      level_q         <= '0;
      misses_q        <= '0;
      symGenMax_q     <= BASE_PERIOD;
      expected_q      <= '0;
      answer_q        <= '0;
      timedOut_q      <= 1'b0;
      resultCorrect_q <= 1'b0;
      gameSig_q       <= 1'b0;
      answerPrompt_q  <= 1'b0;
      resultValid_q   <= 1'b0;
      gameOver_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      score_q         <= score_d;
      level_q         <= level_d;
      misses_q        <= misses_d;
      symGenMax_q     <= symGenMax_d;
      expected_q      <= expected_d;
      answer_q        <= answer_d;
      timedOut_q      <= timedOut_d;
      resultCorrect_q <= resultCorrect_d;
      gameSig_q       <= (state_d == START);
      answerPrompt_q  <= (state_d == ANSWER);
      resultValid_q   <= (state_d == SHOW);
      gameOver_q      <= (state_d == DONE);
      busy_q          <= (state_d != IDLE) && (state_d != DONE);
    end
  end

  assign gameSig       = gameSig_q;
  assign symGenMax     = symGenMax_q;
  assign answerPrompt  = answerPrompt_q;
  assign resultValid   = resultValid_q;
  assign resultCorrect = resultCorrect_q;
  assign score         = score_q;
  assign level         = level_q;
  assign misses        = misses_q;
  assign gameOver      = gameOver_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized self-checking bench for game_round_ctrl with a round-level
// reference model of score, level, misses and symbol period.
module tb_game_round_ctrl;

  localparam logic [31:0] BASE = 32'd100;
  localparam logic [31:0] STEP = 32'd10;
  localparam logic [31:0] MINP = 32'd40;
  localparam int TICK_EVERY = 50;

  logic        Clk100M = 1'b0;
  logic        Rst_n = 1'b0;
  logic        tick1Hz = 1'b0;
  logic        startBtn = 1'b0;
  logic        submitBtn = 1'b0;
  logic        answerSig = 1'b0;
  logic [7:0]  playerAnswer = 8'd0;
  logic [7:0]  numSpecial = 8'd0;
  logic        gameSig;
  logic [31:0] symGenMax;
  logic        answerPrompt;
  logic        resultValid;
  logic        resultCorrect;
  logic [15:0] score;
  logic [3:0]  level;
  logic [1:0]  misses;
  logic        gameOver;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int mScore = 0;
  int mLevel = 0;
  int mMisses = 0;
  logic [7:0] lastSubmitted = 8'd0;

  game_round_ctrl #(
    .BASE_PERIOD(BASE),
    .PERIOD_STEP(STEP),
    .MIN_PERIOD (MINP)
  ) dut (
    .Clk100M      (Clk100M),
    .Rst_n        (Rst_n),
    .tick1Hz      (tick1Hz),
    .startBtn     (startBtn),
    .submitBtn    (submitBtn),
    .playerAnswer (playerAnswer),
    .answerSig    (answerSig),
    .numSpecial   (numSpecial),
    .gameSig      (gameSig),
    .symGenMax    (symGenMax),
    .answerPrompt (answerPrompt),
    .resultValid  (resultValid),
    .resultCorrect(resultCorrect),
    .score        (score),
    .level        (level),
    .misses       (misses),
    .gameOver     (gameOver),
    .busy         (busy)
  );

  // 100 MHz-style clock, 10 time units per cycle.
  always #5 Clk100M = ~Clk100M;

  // One-cycle tick every TICK_EVERY cycles, changed 1 unit after the edge.
  initial begin
    forever begin
      repeat (TICK_EVERY - 1) @(posedge Clk100M);
      #1 tick1Hz = 1'b1;
      @(posedge Clk100M);
      #1 tick1Hz = 1'b0;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #900000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit exceeded");
  end

  function automatic logic [31:0] expPeriod(input int lvl);
    int p;
    p = int'(BASE) - lvl * int'(STEP);
    if (p < int'(MINP)) p = int'(MINP);
    return 32'(p);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of pulses; reports whether a tick is sampled at that edge.
  task automatic applyStimulus(input logic st, input logic sub, input logic ans,
                               output bit tickSeen);
    startBtn  = st;
    submitBtn = sub;
    answerSig = ans;
    tickSeen  = tick1Hz;
    @(posedge Clk100M);
    #2;
    startBtn  = 1'b0;
    submitBtn = 1'b0;
    answerSig = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gamesig"}, 32'(gameSig), 0);
    checkOutput({tag, "_sym"}, symGenMax, BASE);
    checkOutput({tag, "_prompt"}, 32'(answerPrompt), 0);
    checkOutput({tag, "_valid"}, 32'(resultValid), 0);
    checkOutput({tag, "_correct"}, 32'(resultCorrect), 0);
    checkOutput({tag, "_score"}, 32'(score), 0);
    checkOutput({tag, "_level"}, 32'(level), 0);
    checkOutput({tag, "_misses"}, 32'(misses), 0);
    checkOutput({tag, "_gameover"}, 32'(gameOver), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Called where gameSig should be high; leaves the bench at RUN entry.
  task automatic checkRoundStart();
    bit t;
    checkOutput("gamesig_on", 32'(gameSig), 1);
    checkOutput("sym_at_start", symGenMax, expPeriod(mLevel));
    checkOutput("busy_at_start", 32'(busy), 1);
    checkOutput("score_at_start", 32'(score), 32'(mScore));
    checkOutput("level_at_start", 32'(level), 32'(mLevel));
    checkOutput("misses_at_start", 32'(misses), 32'(mMisses));
    checkOutput("gameover_at_start", 32'(gameOver), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, t);
    checkOutput("gamesig_width", 32'(gameSig), 0);
    checkOutput("sym_in_run", symGenMax, expPeriod(mLevel));
  endtask

  task automatic startGame();
    bit t;
    applyStimulus(1'b1, 1'b0, 1'b0, t);
    mScore = 0;
    mLevel = 0;
    mMisses = 0;
    checkRoundStart();
  endtask

  // Modes: 0 correct, 1 wrong, 2 answer timeout, 3 submit on final tick, 4 RUN watchdog.
  task automatic playRound(input int mode);
    bit t;
    int ticks;
    int dly;
    logic [7:0] ns;
    logic expCorrect;
    expCorrect = 1'b0;
    ticks = 0;
    if (mode == 4) begin
      applyStimulus(1'b1, 1'b0, 1'b0, t);
      if (t) ticks++;
      while (ticks < 20) begin
        applyStimulus(1'b0, 1'b0, 1'b0, t);
        if (t) begin
          ticks++;
          if (ticks == 19) checkOutput("wd_not_early", 32'(gameOver), 0);
        end
      end
      checkOutput("wd_gameover", 32'(gameOver), 1);
      checkOutput("wd_busy", 32'(busy), 0);
      checkOutput("wd_gamesig", 32'(gameSig), 0);
      return;
    end

    dly = $urandom_range(0, 150);
    repeat (dly) applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0, t);
    ns = (mode == 2) ? lastSubmitted : 8'($urandom);
    numSpecial = ns;
    applyStimulus(1'b0, 1'b0, 1'b1, t);
    numSpecial = 8'($urandom);
    checkOutput("prompt_on", 32'(answerPrompt), 1);

    case (mode)
      0, 1: begin
        dly = $urandom_range(0, 300);
        repeat (dly) applyStimulus(1'b0, 1'b0, $urandom_range(0, 7) == 0, t);
        playerAnswer = (mode == 0) ? ns : ns ^ 8'($urandom_range(1, 255));
        lastSubmitted = playerAnswer;
        expCorrect = (mode == 0);
        applyStimulus(1'b0, 1'b1, 1'b0, t);
        playerAnswer = 8'($urandom);
      end
      2: begin
        while (ticks < 10) begin
          if (ticks == 9 && tick1Hz) checkOutput("prompt_before_timeout", 32'(answerPrompt), 1);
          applyStimulus(1'b0, 1'b0, 1'b0, t);
          if (t) ticks++;
        end
        expCorrect = 1'b0;
      end
      default: begin
        while (ticks < 10) begin
          if (ticks == 9 && tick1Hz) begin
            playerAnswer = ns;
            lastSubmitted = ns;
            applyStimulus(1'b0, 1'b1, 1'b0, t);
          end else begin
            applyStimulus(1'b0, 1'b0, 1'b0, t);
          end
          if (t) ticks++;
        end
        expCorrect = 1'b1;
      end
    endcase

    checkOutput("prompt_off", 32'(answerPrompt), 0);
    checkOutput("judge_no_result", 32'(resultValid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, t);

    if (expCorrect) begin
      mScore = (mScore + mLevel + 1 > 65535) ? 65535 : mScore + mLevel + 1;
      mLevel = (mLevel < 7) ? mLevel + 1 : 7;
    end else begin
      mMisses++;
    end
    checkOutput("result_valid", 32'(resultValid), 1);
    checkOutput("result_correct", 32'(resultCorrect), 32'(expCorrect));
    checkOutput("score", 32'(score), 32'(mScore));
    checkOutput("level", 32'(level), 32'(mLevel));
    checkOutput("misses", 32'(misses), 32'(mMisses));
    checkOutput("sym_after_judge", symGenMax, expPeriod(mLevel));

    ticks = 0;
    while (ticks < 3) begin
      applyStimulus(1'b0, 1'b0, $urandom_range(0, 7) == 0, t);
      if (t) begin
        ticks++;
        if (ticks == 2) checkOutput("show_hold", 32'(resultValid), 1);
      end
    end
    if (mMisses == 3) begin
      checkOutput("done_gameover", 32'(gameOver), 1);
      checkOutput("done_busy", 32'(busy), 0);
      checkOutput("done_gamesig", 32'(gameSig), 0);
    end else begin
      checkRoundStart();
    end
  endtask

  initial begin
    bit t;
    int n;
    repeat (3) @(posedge Clk100M);
    #2;
    checkResetState("rst");
    Rst_n = 1'b1;
    repeat (20) applyStimulus(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, t);
    checkOutput("idle_gamesig", 32'(gameSig), 0);
    checkOutput("idle_busy", 32'(busy), 0);

    $display("[TB] game 1: correct streak then random rounds");
    startGame();
    repeat (9) playRound(0);
    n = 0;
    while (mMisses < 3 && n < 20) begin
      playRound((n >= 8) ? 1 : $urandom_range(0, 3));
      n++;
    end

    $display("[TB] game 2: timeout, coincident submit, watchdog");
    startGame();
    playRound(2);
    playRound(3);
    playRound(4);

    $display("[TB] game 3: reset during answer entry");
    startGame();
    repeat ($urandom_range(0, 100)) applyStimulus(1'b0, 1'b0, 1'b0, t);
    numSpecial = 8'($urandom);
    applyStimulus(1'b0, 1'b0, 1'b1, t);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, t);
    checkOutput("pre_reset_prompt", 32'(answerPrompt), 1);
    Rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    @(posedge Clk100M);
    #2;
    Rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, t);
    checkOutput("post_reset_busy", 32'(busy), 0);
    checkOutput("post_reset_gamesig", 32'(gameSig), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
